// File: rtl/l2_wb_buffer.sv
// Purpose: victim buffer that queues dirty L2 lines for write-back and answers refill lookups.
// Latency: accept in cycle N, line captured in N+1, earliest memory write offered in N+2.
// Backpressure: evict_ready_o drops while full; the head entry is held stable until mem_wready_i.
module l2_wb_buffer #(
  parameter int LINE_WIDTH     = 128,
  parameter int IDX_WIDTH      = 8,
  parameter int BLK_ADDR_WIDTH = 28,
  parameter int DEPTH          = 4,
  parameter int PTR_WIDTH      = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      evict_valid_i,
  output logic                      evict_ready_o,
  input  logic [BLK_ADDR_WIDTH-1:0] evict_blk_addr_i,
  output logic [IDX_WIDTH-1:0]      l2_rd_idx_o,
  input  logic [LINE_WIDTH-1:0]     l2_rdata_i,
  output logic                      mem_wvalid_o,
  input  logic                      mem_wready_i,
  output logic [BLK_ADDR_WIDTH-1:0] mem_waddr_o,
  output logic [LINE_WIDTH-1:0]     mem_wdata_o,
  input  logic [BLK_ADDR_WIDTH-1:0] lkp_blk_addr_i,
  output logic                      lkp_hit_o,
  output logic                      lkp_busy_o,
  output logic [LINE_WIDTH-1:0]     lkp_data_o,
  output logic [PTR_WIDTH:0]        count_o,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH+1)'(DEPTH);

  logic [DEPTH-1:0]          valid_q;
  logic [DEPTH-1:0]          dvalid_q;
  logic [BLK_ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [LINE_WIDTH-1:0]     data_q [DEPTH];
  logic [PTR_WIDTH-1:0]      wr_ptr_q;
  logic [PTR_WIDTH-1:0]      rd_ptr_q;
  logic [PTR_WIDTH:0]        count_q;
  logic                      cap_vld_q;
  logic [PTR_WIDTH-1:0]      cap_ptr_q;

  logic                      accept;
  logic                      drain;
  logic                      head_rdy;
  logic                      lkp_found;
  logic [PTR_WIDTH-1:0]      lkp_idx;
  logic [PTR_WIDTH-1:0]      lkp_scan;

  assign full_o        = (count_q == FULL_CNT);
  assign empty_o       = (count_q == '0);
  assign count_o       = count_q;
  assign evict_ready_o = !full_o;
  assign l2_rd_idx_o   = evict_blk_addr_i[IDX_WIDTH-1:0];

  assign accept   = evict_valid_i && evict_ready_o;
  assign head_rdy = valid_q[rd_ptr_q] && dvalid_q[rd_ptr_q];
  assign drain    = head_rdy && mem_wready_i;

  // Head entry is only exposed once its data is captured; the gating also hides
  // the unreset storage arrays after reset.
  assign mem_wvalid_o = head_rdy;
  assign mem_waddr_o  = head_rdy ? addr_q[rd_ptr_q] : '0;
  assign mem_wdata_o  = head_rdy ? data_q[rd_ptr_q] : '0;

  // Entry flags, pointers, occupancy and the one-deep capture stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= '0;
      dvalid_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      cap_vld_q <= 1'b0;
      cap_ptr_q <= '0;
    end else begin
      // Capture, drain and allocate always hit distinct entries, so their
      // flag updates never collide.
      if (cap_vld_q) begin
        dvalid_q[cap_ptr_q] <= 1'b1;
      end
      if (drain) begin
        valid_q[rd_ptr_q]  <= 1'b0;
        dvalid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q           <= rd_ptr_q + PTR_WIDTH'(1);
      end
      if (accept) begin
        valid_q[wr_ptr_q]  <= 1'b1;
        dvalid_q[wr_ptr_q] <= 1'b0;
        wr_ptr_q           <= wr_ptr_q + PTR_WIDTH'(1);
      end
      cap_vld_q <= accept;
      cap_ptr_q <= wr_ptr_q;
      if (accept && !drain) begin
        count_q <= count_q + (PTR_WIDTH+1)'(1);
      end else if (drain && !accept) begin
        count_q <= count_q - (PTR_WIDTH+1)'(1);
      end
    end
  end

  // Address and line storage; contents are qualified by the flags above.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      addr_q[wr_ptr_q] <= evict_blk_addr_i;
    end
    if (cap_vld_q) begin
      data_q[cap_ptr_q] <= l2_rdata_i;
    end
  end

  // Walk entries oldest to youngest from the read pointer; the last match seen is the youngest.
  always_comb begin
    lkp_found = 1'b0;
    lkp_idx   = '0;
    lkp_scan  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lkp_scan = rd_ptr_q + PTR_WIDTH'(i);
      if (valid_q[lkp_scan] && (addr_q[lkp_scan] == lkp_blk_addr_i)) begin
        lkp_found = 1'b1;
        lkp_idx   = lkp_scan;
      end
    end
  end

  assign lkp_hit_o  = lkp_found && dvalid_q[lkp_idx];
  assign lkp_busy_o = lkp_found && !dvalid_q[lkp_idx];
  assign lkp_data_o = lkp_hit_o ? data_q[lkp_idx] : '0;

endmodule

// File: tb/tb_l2_wb_buffer.sv
// Purpose: randomized and directed bench for l2_wb_buffer against a queue-based model.
// Latency: model exposes captured lines two cycles after accept, matching the buffer contract.
// Backpressure: mem_wready_i and evict_valid_i are toggled randomly to exercise stalls and full.
module tb_l2_wb_buffer;
  localparam int LW    = 128;
  localparam int IW    = 8;
  localparam int AW    = 28;
  localparam int DEPTH = 4;
  localparam int PW    = 2;

  logic          clk_i            = 1'b0;
  logic          rst_ni           = 1'b0;
  logic          evict_valid_i    = 1'b0;
  logic [AW-1:0] evict_blk_addr_i = '0;
  logic [LW-1:0] l2_rdata_i       = '0;
  logic          mem_wready_i     = 1'b0;
  logic [AW-1:0] lkp_blk_addr_i   = '0;
  logic          evict_ready_o;
  logic [IW-1:0] l2_rd_idx_o;
  logic          mem_wvalid_o;
  logic [AW-1:0] mem_waddr_o;
  logic [LW-1:0] mem_wdata_o;
  logic          lkp_hit_o;
  logic          lkp_busy_o;
  logic [LW-1:0] lkp_data_o;
  logic [PW:0]   count_o;
  logic          full_o;
  logic          empty_o;

  int tests = 0;
  int fails = 0;

  l2_wb_buffer #(
    .LINE_WIDTH(LW), .IDX_WIDTH(IW), .BLK_ADDR_WIDTH(AW), .DEPTH(DEPTH), .PTR_WIDTH(PW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .evict_valid_i(evict_valid_i), .evict_ready_o(evict_ready_o),
    .evict_blk_addr_i(evict_blk_addr_i), .l2_rd_idx_o(l2_rd_idx_o),
    .l2_rdata_i(l2_rdata_i),
    .mem_wvalid_o(mem_wvalid_o), .mem_wready_i(mem_wready_i),
    .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
    .lkp_blk_addr_i(lkp_blk_addr_i), .lkp_hit_o(lkp_hit_o),
    .lkp_busy_o(lkp_busy_o), .lkp_data_o(lkp_data_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk_w(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    chk_w(name, LW'(act), LW'(exp));
  endtask

  function automatic logic [LW-1:0] rep(input logic [AW-1:0] a);
    return {4{4'h0, a}};
  endfunction

  // Reference model: an ordered list of buffered lines, oldest first.
  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
    bit            dv;
  } ent_t;

  ent_t          q[$];
  bit            cap_pend = 0;
  bit            m_wv, m_found, m_dv, acc, drn;
  logic [LW-1:0] m_ldata;
  ent_t          e;

  // Compare DUT against the model every cycle, then advance the model across the coming edge.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      chk_b("rst_evict_ready", evict_ready_o, 1'b1);
      chk_b("rst_wvalid", mem_wvalid_o, 1'b0);
      chk_w("rst_waddr", LW'(mem_waddr_o), '0);
      chk_w("rst_wdata", mem_wdata_o, '0);
      chk_b("rst_hit", lkp_hit_o, 1'b0);
      chk_b("rst_busy", lkp_busy_o, 1'b0);
      chk_w("rst_ldata", lkp_data_o, '0);
      chk_w("rst_count", LW'(count_o), '0);
      chk_b("rst_full", full_o, 1'b0);
      chk_b("rst_empty", empty_o, 1'b1);
      q.delete();
      cap_pend = 0;
    end else begin
      m_wv    = (q.size() > 0) && q[0].dv;
      m_found = 0;
      m_dv    = 0;
      m_ldata = '0;
      for (int i = 0; i < q.size(); i++) begin
        if (q[i].addr == lkp_blk_addr_i) begin
          m_found = 1;
          m_dv    = q[i].dv;
          m_ldata = q[i].data;
        end
      end
      chk_b("evict_ready", evict_ready_o, q.size() < DEPTH);
      chk_w("l2_rd_idx", LW'(l2_rd_idx_o), LW'(evict_blk_addr_i[IW-1:0]));
      chk_b("mem_wvalid", mem_wvalid_o, m_wv);
      if (m_wv) begin
        chk_w("mem_waddr", LW'(mem_waddr_o), LW'(q[0].addr));
        chk_w("mem_wdata", mem_wdata_o, q[0].data);
      end
      chk_b("lkp_hit", lkp_hit_o, m_found && m_dv);
      chk_b("lkp_busy", lkp_busy_o, m_found && !m_dv);
      if (!(m_found && !m_dv)) chk_w("lkp_data", lkp_data_o, (m_found && m_dv) ? m_ldata : '0);
      chk_w("count", LW'(count_o), LW'(q.size()));
      chk_b("full", full_o, q.size() == DEPTH);
      chk_b("empty", empty_o, q.size() == 0);

      acc = evict_valid_i && (q.size() < DEPTH);
      drn = m_wv && mem_wready_i;
      if (cap_pend) begin
        e      = q[q.size()-1];
        e.dv   = 1;
        e.data = l2_rdata_i;
        q[q.size()-1] = e;
      end
      if (drn) void'(q.pop_front());
      if (acc) begin
        e.addr = evict_blk_addr_i;
        e.data = '0;
        e.dv   = 0;
        q.push_back(e);
      end
      cap_pend = acc;
    end
  end

  task automatic drv(input logic ev, input logic [AW-1:0] a, input logic [LW-1:0] d,
                     input logic wr, input logic [AW-1:0] l);
    evict_valid_i    = ev;
    evict_blk_addr_i = a;
    l2_rdata_i       = d;
    mem_wready_i     = wr;
    lkp_blk_addr_i   = l;
  endtask

  task automatic neg();
    @(negedge clk_i);
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  localparam logic [LW-1:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [LW-1:0] RA = 128'hA5A5A5A5_00000ABC_5A5A5A5A_11112222;
  localparam logic [LW-1:0] DA = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA;
  localparam logic [LW-1:0] DB = 128'hBBBBBBBB_BBBBBBBB_BBBBBBBB_BBBBBBBB;

  logic [AW-1:0] pool [7];

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    neg();
    chk_b("init_empty", empty_o, 1'b1);
    chk_b("init_ready", evict_ready_o, 1'b1);
    nxt();

    // Single eviction with memory always ready.
    drv(1'b1, 28'h0000123, '0, 1'b1, 28'h0000123);
    neg(); chk_w("t1_rd_idx", LW'(l2_rd_idx_o), LW'(8'h23)); chk_b("t1_rdy", evict_ready_o, 1'b1); nxt();
    drv(1'b0, '0, D1, 1'b1, '0);
    neg(); chk_b("t1_n1_wvalid", mem_wvalid_o, 1'b0); chk_w("t1_n1_count", LW'(count_o), LW'(1)); nxt();
    drv(1'b0, '0, '0, 1'b1, '0);
    neg(); chk_b("t1_n2_wvalid", mem_wvalid_o, 1'b1);
    chk_w("t1_n2_waddr", LW'(mem_waddr_o), LW'(28'h0000123)); chk_w("t1_n2_wdata", mem_wdata_o, D1); nxt();
    drv(1'b0, '0, '0, 1'b0, '0);
    neg(); chk_w("t1_n3_count", LW'(count_o), '0); chk_b("t1_n3_empty", empty_o, 1'b1); nxt();

    // Fill with four lines while memory stalls.
    for (int i = 0; i < 5; i++) begin
      drv(i < 4, AW'(32'h10 + i), (i > 0) ? rep(AW'(32'h10 + i - 1)) : '0, 1'b0, '0);
      neg(); nxt();
    end
    drv(1'b1, 28'h14, '0, 1'b0, '0);
    neg(); chk_b("t2_full", full_o, 1'b1); chk_b("t2_rdy", evict_ready_o, 1'b0);
    chk_w("t2_count", LW'(count_o), LW'(4)); chk_w("t2_head", LW'(mem_waddr_o), LW'(28'h10)); nxt();
    drv(1'b1, 28'h14, '0, 1'b1, '0);
    neg(); chk_b("t2_d0_rdy", evict_ready_o, 1'b0); chk_w("t2_d0_addr", LW'(mem_waddr_o), LW'(28'h10));
    chk_w("t2_d0_data", mem_wdata_o, rep(28'h10)); nxt();
    drv(1'b1, 28'h14, '0, 1'b0, '0);
    neg(); chk_w("t2_d1_count", LW'(count_o), LW'(3)); chk_b("t2_d1_rdy", evict_ready_o, 1'b1); nxt();
    drv(1'b0, '0, rep(28'h14), 1'b1, '0);
    neg(); chk_w("t2_d2_count", LW'(count_o), LW'(4)); chk_w("t2_d2_addr", LW'(mem_waddr_o), LW'(28'h11)); nxt();
    for (int i = 2; i < 5; i++) begin
      drv(1'b0, '0, '0, 1'b1, '0);
      neg(); chk_w("t2_drain_addr", LW'(mem_waddr_o), LW'(AW'(32'h10 + i)));
      chk_w("t2_drain_data", mem_wdata_o, rep(AW'(32'h10 + i))); nxt();
    end
    drv(1'b0, '0, '0, 1'b0, '0);
    neg(); chk_b("t2_empty", empty_o, 1'b1); nxt();

    // Lookup while capture is in flight, after capture, and on a miss.
    drv(1'b1, 28'h0000ABC, '0, 1'b0, 28'h0000ABC);
    neg(); chk_b("t3_pre_busy", lkp_busy_o, 1'b0); chk_b("t3_pre_hit", lkp_hit_o, 1'b0); nxt();
    drv(1'b0, '0, RA, 1'b0, 28'h0000ABC);
    neg(); chk_b("t3_busy", lkp_busy_o, 1'b1); chk_b("t3_busy_hit", lkp_hit_o, 1'b0); nxt();
    drv(1'b0, '0, '0, 1'b0, 28'h0000ABC);
    neg(); chk_b("t3_hit", lkp_hit_o, 1'b1); chk_w("t3_data", lkp_data_o, RA); nxt();
    drv(1'b0, '0, '0, 1'b0, 28'h0005555);
    neg(); chk_b("t3_miss_hit", lkp_hit_o, 1'b0); chk_b("t3_miss_busy", lkp_busy_o, 1'b0);
    chk_w("t3_miss_data", lkp_data_o, '0); nxt();

    // Duplicate address: youngest copy wins the lookup, both copies drain in order.
    drv(1'b1, 28'h20, '0, 1'b0, 28'h20); neg(); nxt();
    drv(1'b1, 28'h20, DA, 1'b0, 28'h20); neg(); nxt();
    drv(1'b0, '0, DB, 1'b0, 28'h20); neg(); chk_b("t4_young_busy", lkp_busy_o, 1'b1); nxt();
    drv(1'b0, '0, '0, 1'b0, 28'h20);
    neg(); chk_b("t4_hit", lkp_hit_o, 1'b1); chk_w("t4_data", lkp_data_o, DB); chk_w("t4_count", LW'(count_o), LW'(3)); nxt();
    drv(1'b0, '0, '0, 1'b1, 28'h20);
    neg(); chk_w("t4_w0_addr", LW'(mem_waddr_o), LW'(28'hABC)); chk_w("t4_w0_data", mem_wdata_o, RA); nxt();
    neg(); chk_w("t4_w1_addr", LW'(mem_waddr_o), LW'(28'h20)); chk_w("t4_w1_data", mem_wdata_o, DA); nxt();
    neg(); chk_w("t4_w2_data", mem_wdata_o, DB); chk_b("t4_w2_hit", lkp_hit_o, 1'b1);
    chk_w("t4_w2_ldata", lkp_data_o, DB); nxt();
    drv(1'b0, '0, '0, 1'b0, '0);
    neg(); chk_b("t4_empty", empty_o, 1'b1); nxt();

    // Reset asserted during the capture cycle.
    drv(1'b1, 28'h77, '0, 1'b1, 28'h77); neg(); nxt();
    drv(1'b0, '0, D1, 1'b1, 28'h77);
    #1 rst_ni = 1'b0;
    #1;
    chk_b("t6_rdy", evict_ready_o, 1'b1); chk_w("t6_count", LW'(count_o), '0);
    chk_b("t6_empty", empty_o, 1'b1); chk_b("t6_busy", lkp_busy_o, 1'b0);
    neg(); nxt();
    rst_ni = 1'b1;
    neg(); chk_b("t6_post_empty", empty_o, 1'b1); chk_b("t6_post_wvalid", mem_wvalid_o, 1'b0); nxt();
    neg(); chk_b("t6_post2_wvalid", mem_wvalid_o, 1'b0); nxt();

    // Random traffic over a small address pool to provoke duplicates and hits.
    pool[0] = 28'h1; pool[1] = 28'h2; pool[2] = 28'h3; pool[3] = 28'h101;
    pool[4] = 28'hFFFFFFF; pool[5] = 28'h1234567; pool[6] = 28'h0BADBAD;
    for (int c = 0; c < 2000; c++) begin
      drv(($urandom % 3) != 0, pool[$urandom % 6], {$urandom, $urandom, $urandom, $urandom},
          ($urandom % 2) == 0, pool[$urandom % 7]);
      if (c == 900) rst_ni = 1'b0;
      if (c == 902) rst_ni = 1'b1;
      nxt();
    end
    drv(1'b0, '0, '0, 1'b1, '0);
    repeat (8) nxt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
